tinker_mem_arbiter: RTL and testbench
=====================================

# tinker_mem_arbiter

Arbitrates the single shared Tinker memory port between the instruction-fetch requester and the data requester. The data requester carries load, store, call and return traffic. Each side uses a valid/ready request channel and a one-cycle response pulse. The arbiter sequences each transaction against a fixed-latency memory, one transaction at a time. It sits between the pipeline's IF/EX_MEM stages and the byte-addressed memory block.

## Interface
Parameters:
- ADDR_W, 32, byte address width.
- LAT, 2, memory read latency in cycles; legal range ≥1.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- if_req_valid  in  1  fetch request pending.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_rsp_valid  out  1  fetch data valid, one-cycle pulse.
- if_rsp_data  out  32  instruction word.
- d_req_valid  in  1  data request pending.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  64  store data.
- d_rsp_valid  out  1  load data or store acknowledge, one-cycle pulse.
- d_rsp_data  out  64  load data; 0 on store acknowledge.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid LAT cycles after mem_en rises.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: accepts a request → BUSY.
  - BUSY: counts LAT cycles → RESP.
  - RESP: drives one response cycle → IDLE.
- Grant is evaluated only in IDLE. Exactly one ready rises, combinationally, on the granted valid.
- Default priority is data over fetch.
- Starvation rule: starve_cnt counts data grants made while if_req_valid=1. It saturates at STARVE_MAX.
  - When starve_cnt == STARVE_MAX and both valids are high, fetch wins.
  - Any fetch grant clears starve_cnt to 0.
- On accept, latch requester ID, we, addr and wdata. The requester may drop or change its inputs afterwards.
- Requesters hold valid, addr and data stable until ready is seen. The arbiter never retracts a ready within the same cycle.
- BUSY outputs:
  - mem_en=1 for all LAT cycles.
  - mem_addr and mem_wdata come from the latched values.
  - mem_we=1 on the first BUSY cycle only, for stores only.
- On the last BUSY cycle, capture mem_rdata into the response register.
- RESP outputs:
  - Only the owning side's rsp_valid is 1.
  - Fetch responses return mem_rdata[31:0].
  - Load responses return all 64 bits.
  - Store responses return d_rsp_data=0.
- Address alignment is not checked. Addresses pass through unchanged, with no wrap handling beyond ADDR_W truncation.

## Timing
- Reset (async) values:
  - state=IDLE, starve_cnt=0, all latched registers 0.
  - Every output 0: both readys, rsp_valid/rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy.
- Latency: a request accepted on the edge ending cycle t produces rsp_valid high in cycle t+LAT+1.
- Throughput: one transaction per LAT+2 cycles. Readys are 0 in BUSY and RESP.
- Simultaneous valids in IDLE: resolved by the priority and starvation rule above. There is no accept in RESP.
- Reset asserted mid-transaction: the transaction is abandoned. No rsp_valid is produced, and mem_we drops immediately.
- With LAT=1: BUSY lasts one cycle, and mem_we and the read capture happen in that same cycle.

## Configuration
- TINKER_ARB_STARVE_EN defined: starvation counter and fetch-override rule present, as above.
- TINKER_ARB_STARVE_EN undefined:
  - Strict data priority; fetch is granted only when d_req_valid=0.
  - starve_cnt logic and STARVE_MAX usage are compiled out.
  - Port list is unchanged.

## Structure
- Package tinker_arb_pkg:
  - typedef arb_state_t {ARB_IDLE, ARB_BUSY, ARB_RESP}.
  - typedef arb_owner_t {OWN_IF, OWN_D}.
  - Constants INST_W=32, DATA_W=64.
- Sub-module tinker_arb_starve_ctr: saturating counter with inc/clr inputs and a sat output. It is instantiated only under TINKER_ARB_STARVE_EN.

## Test plan
Parameters for all scenarios: LAT=2, STARVE_MAX=4. Memory is preloaded with word 0x8000_0013 at 0x2000 and 64'h1122_3344_5566_7788 at 0x100.

1. Fetch only, if_addr=0x2000, accepted at t → if_rsp_valid in cycle t+3 with data 0x8000_0013; busy high for cycles t+1..t+3.
2. Load at d_addr=0x100 → d_rsp_data=64'h1122_3344_5566_7788. Store of 64'hDEAD_BEEF to 0x200 → mem_we high for exactly 1 cycle, ack with data 0. A reload of 0x200 then returns 64'hDEAD_BEEF.
3. Both valids held high continuously → data granted 4 times, then fetch, repeating. With the macro undefined, fetch is never granted.
4. Both valids rise in the same IDLE cycle with starve_cnt=0 → d_req_ready=1, if_req_ready=0.
5. Reset pulsed in the second BUSY cycle of a load → no d_rsp_valid; all outputs 0 while reset is high. The next request completes normally in LAT+1 cycles.
6. Request inputs changed after accept (addr, wdata) → the memory sees the latched values; the response matches the original request.

Source files
------------

// File: rtl/tinker_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tinker_arb_pkg: shared types and widths for the Tinker memory arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package tinker_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } arb_owner_t;

  localparam int INST_W = 32;
  localparam int DATA_W = 64;

endpackage

`default_nettype wire

// File: rtl/tinker_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// tinker_mem_arbiter_if: fetch/data request channels and shared memory port.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tinker_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import tinker_arb_pkg::*;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [INST_W-1:0] if_rsp_data;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter side
  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_req_we, d_addr, d_wdata, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid,
           d_rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_req_we, d_addr, d_wdata, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid,
           d_rsp_data, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

`default_nettype wire

// File: rtl/tinker_mem_arbiter_starve_ctr.sv
// ----------------------------------------------------------------------------
// tinker_arb_starve_ctr: saturating count of data grants made while fetch waits.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tinker_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && !sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat = (r_cnt == CW'(MAX));

endmodule

`default_nettype wire

// File: rtl/tinker_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tinker_mem_arbiter: fetch/data arbiter for a fixed-latency shared memory port.
// Optional fetch anti-starvation override: TINKER_ARB_STARVE_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tinker_mem_arbiter
  import tinker_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tinker_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LAT - 1);

  if (LAT < 1) begin : g_bad_lat
    $error("tinker_mem_arbiter: LAT must be >= 1");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("tinker_mem_arbiter: STARVE_MAX must be >= 1");
  end

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rsp;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic              w_fetch_win;
  logic              w_grant_if;
  logic              w_grant_d;
  logic              w_last;

`ifdef TINKER_ARB_STARVE_EN
  logic w_starve_sat;

  tinker_arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (w_grant_d & bus.if_req_valid),
    .clr   (w_grant_if),
    .sat   (w_starve_sat)
  );

  assign w_fetch_win = bus.if_req_valid & (~bus.d_req_valid | w_starve_sat);
`else
  assign w_fetch_win = bus.if_req_valid & ~bus.d_req_valid;
`endif

  // Readys are masked by reset so nothing is accepted while it is asserted.
  assign w_grant_if = (r_state == ARB_IDLE) & ~reset & w_fetch_win;
  assign w_grant_d  = (r_state == ARB_IDLE) & ~reset & bus.d_req_valid & ~w_fetch_win;
  assign w_last     = (r_lat_cnt == C_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    bus.if_req_ready = 1'b0;
    bus.d_req_ready  = 1'b0;
    bus.if_rsp_valid = 1'b0;
    bus.if_rsp_data  = '0;
    bus.d_rsp_valid  = 1'b0;
    bus.d_rsp_data   = '0;
    bus.mem_en       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.busy         = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        bus.if_req_ready = w_grant_if;
        bus.d_req_ready  = w_grant_d;
        if (w_grant_if || w_grant_d) begin
          w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        bus.busy      = 1'b1;
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_we & (r_lat_cnt == '0);
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        if (w_last) begin
          w_state_nxt = ARB_RESP;
        end
      end
      ARB_RESP: begin
        bus.busy = 1'b1;
        if (r_owner == OWN_IF) begin
          bus.if_rsp_valid = 1'b1;
          bus.if_rsp_data  = r_rsp[INST_W-1:0];
        end else begin
          bus.d_rsp_valid = 1'b1;
          bus.d_rsp_data  = r_rsp;
        end
        w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Request fields are latched at accept; requesters are free afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner   <= OWN_IF;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rsp     <= '0;
      r_lat_cnt <= '0;
    end else if (w_grant_if || w_grant_d) begin
      r_owner   <= w_grant_d ? OWN_D : OWN_IF;
      r_we      <= w_grant_d & bus.d_req_we;
      r_addr    <= w_grant_d ? bus.d_addr : bus.if_addr;
      r_wdata   <= w_grant_d ? bus.d_wdata : '0;
      r_lat_cnt <= '0;
    end else if (r_state == ARB_BUSY) begin
      r_lat_cnt <= r_lat_cnt + 1'b1;
      if (w_last) begin
        r_rsp <= r_we ? '0 : bus.mem_rdata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tinker_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tinker_mem_arbiter: directed bench for tinker_mem_arbiter (LAT=2, STARVE_MAX=4).
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tinker_mem_arbiter;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   we_pulses = 0;
  int   en_cnt;
  logic [63:0] mem [0:8191];

  always #5 clk = ~clk;

  tinker_mem_arbiter_if #(.ADDR_W(32)) bus ();

  tinker_mem_arbiter #(
    .ADDR_W     (32),
    .LAT        (LAT),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: read data is only valid on the last cycle of the access.
  always @(posedge clk or posedge reset) begin
    if (reset) en_cnt <= 0;
    else if (bus.mem_en) en_cnt <= en_cnt + 1;
    else en_cnt <= 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      mem[13'h0400] <= 64'h0000_0000_8000_0013;
      mem[13'h0020] <= 64'h1122_3344_5566_7788;
    end else if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[15:3]] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_we) we_pulses <= we_pulses + 1;
  end

  assign bus.mem_rdata = (bus.mem_en && en_cnt == LAT - 1) ? mem[bus.mem_addr[15:3]]
                                                           : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ctrl"}, {57'd0, bus.if_req_ready, bus.d_req_ready, bus.if_rsp_valid,
        bus.d_rsp_valid, bus.mem_en, bus.mem_we, bus.busy}, 64'd0);
    chk({tag, " membus"}, bus.mem_wdata | 64'(bus.mem_addr), 64'd0);
    chk({tag, " rspdata"}, bus.d_rsp_data | 64'(bus.if_rsp_data), 64'd0);
  endtask

  // One full transaction from an idle arbiter; inputs are scrambled after accept.
  task automatic txn(input string tag, input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [63:0] wdata, input logic [63:0] exp);
    int p0;
    @(negedge clk);
    if (is_d) begin
      bus.d_req_valid = 1'b1; bus.d_req_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.if_req_valid = 1'b1; bus.if_addr = addr;
    end
    #1;
    chk({tag, " ready"}, {62'd0, bus.d_req_ready, bus.if_req_ready}, is_d ? 64'd2 : 64'd1);
    p0 = we_pulses;
    @(negedge clk);
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    bus.if_addr = ~addr; bus.d_addr = ~addr; bus.d_wdata = ~wdata; bus.d_req_we = ~we;
    #1;
    chk({tag, " busy1"}, {61'd0, bus.busy, bus.mem_en, bus.mem_we}, {61'd0, 1'b1, 1'b1, we});
    chk({tag, " addr"}, 64'(bus.mem_addr), 64'(addr));
    if (is_d) chk({tag, " wdata"}, bus.mem_wdata, wdata);
    @(negedge clk);
    chk({tag, " busy2"}, {60'd0, bus.busy, bus.mem_en, bus.mem_we,
        bus.if_rsp_valid | bus.d_rsp_valid}, 64'b1100);
    @(negedge clk);
    chk({tag, " rspv"}, {62'd0, bus.d_rsp_valid, bus.if_rsp_valid}, is_d ? 64'd2 : 64'd1);
    chk({tag, " data"}, is_d ? bus.d_rsp_data : {32'd0, bus.if_rsp_data}, exp);
    chk({tag, " resp busy"}, {62'd0, bus.busy, bus.mem_en}, 64'b10);
    chk({tag, " we pulses"}, 64'(we_pulses - p0), 64'(we));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit exp_d;
    reset = 1'b1;
    bus.if_req_valid = 1'b0; bus.if_addr = '0;
    bus.d_req_valid = 1'b0; bus.d_req_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) @(negedge clk);
    bus.if_req_valid = 1'b1; bus.d_req_valid = 1'b1;
    #1;
    chk_zero("reset");
    bus.if_req_valid = 1'b0; bus.d_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    txn("fetch", 1'b0, 1'b0, 32'h2000, 64'd0, 64'h8000_0013);
    @(negedge clk);
    chk("idle after fetch", 64'(bus.busy), 64'd0);

    txn("load", 1'b1, 1'b0, 32'h100, 64'h0, 64'h1122_3344_5566_7788);
    txn("store", 1'b1, 1'b1, 32'h200, 64'hDEAD_BEEF, 64'd0);
    txn("reload", 1'b1, 1'b0, 32'h200, 64'h5555, 64'hDEAD_BEEF);

    // Both requesters held high: grant sequence shows priority and starvation.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_addr = 32'h100;
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h2000;
      end
      #1;
`ifdef TINKER_ARB_STARVE_EN
      exp_d = ((k % 5) != 4);
`else
      exp_d = 1'b1;
`endif
      chk(k == 0 ? "simultaneous grant" : $sformatf("grant %0d", k),
          {62'd0, bus.d_req_ready, bus.if_req_ready}, exp_d ? 64'd2 : 64'd1);
      if (k < 9) repeat (3) @(negedge clk);
    end
    @(negedge clk);
    bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the second BUSY cycle of a load.
    @(negedge clk);
    bus.d_req_valid = 1'b1; bus.d_req_we = 1'b0; bus.d_addr = 32'h100;
    #1;
    chk("abort ready", 64'(bus.d_req_ready), 64'd1);
    @(negedge clk);
    bus.d_req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.d_req_valid = 1'b1; bus.if_req_valid = 1'b1;
    #1;
    chk_zero("mid reset");
    @(negedge clk);
    chk("no abort rsp", {62'd0, bus.d_rsp_valid, bus.if_rsp_valid}, 64'd0);
    bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
    reset = 1'b0;
    txn("after reset", 1'b1, 1'b0, 32'h100, 64'h0, 64'h1122_3344_5566_7788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
